// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: fills a single-port memory with a pattern, reads it
// back through a one-cycle-latency compare pipeline, and reports the first
// mismatching address and data.
module mem_bist_ctrl #(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(8'h01)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST = '1;
  // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [DATA_W-1:0] SEED = (LFSR_SEED == '0) ? DATA_W'(1) : LFSR_SEED;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] lfsr;
  logic [DATA_W-1:0] exp_q;    // expected data for the read issued last cycle
  logic [ADDR_W-1:0] addr_q;   // address of the read issued last cycle
  logic              cmp_vld;  // mem_rdata this cycle belongs to addr_q
  logic              mismatch;

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] l);
    case (m)
      2'd0:    return '0;
      2'd1:    return DATA_W'(a);
      2'd2:    return l;
      default: return ~(DATA_W'(a));
    endcase
  endfunction

  assign mismatch = cmp_vld && (mem_rdata != exp_q);

  // Controller FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_q    <= '0;
      lfsr      <= SEED;
      exp_q     <= '0;
      addr_q    <= '0;
      cmp_vld   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_WRITE;
            mode_q    <= mode;
            lfsr      <= SEED;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            mem_addr  <= '0;
            mem_wdata <= pattern(mode, '0, SEED);
            mem_write <= 1'b1;
          end
        end
        S_WRITE: begin
          if (mem_addr == LAST) begin
            // Read pass restarts address and LFSR so it regenerates the same data.
            state     <= S_READ;
            mem_write <= 1'b0;
            mem_wdata <= '0;
            mem_read  <= 1'b1;
            mem_addr  <= '0;
            lfsr      <= SEED;
          end else begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            lfsr      <= lfsr_next(lfsr);
            mem_wdata <= pattern(mode_q, mem_addr + ADDR_W'(1), lfsr_next(lfsr));
          end
        end
        S_READ: begin
          cmp_vld <= 1'b1;
          addr_q  <= mem_addr;
          exp_q   <= pattern(mode_q, mem_addr, lfsr);
          if (mismatch) begin
            // First failure ends the test; the read just issued is abandoned.
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            fail_addr <= addr_q;
            fail_data <= mem_rdata;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            cmp_vld   <= 1'b0;
          end else if (mem_addr == LAST) begin
            state    <= S_DRAIN;
            mem_read <= 1'b0;
            mem_addr <= '0;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            lfsr     <= lfsr_next(lfsr);
          end
        end
        S_DRAIN: begin
          // Last location's data arrives now; nothing more is read.
          state     <= S_DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          pass      <= ~mismatch;
          fail_addr <= mismatch ? addr_q : '0;
          fail_data <= mismatch ? mem_rdata : '0;
          cmp_vld   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl: stimulus pushes expected write stream
// and final results; per-DUT monitors pop and compare on each memory write
// and on each rising done.
module tb_mem_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct { int a; int d; } wr_t;
  typedef struct { logic pass; int fa; int fd; int busy; int reads; } res_t;

  // ---------------- DUT A: 32 x 8 ----------------
  logic        start_a = 1'b0, busy_a, done_a, pass_a, we_a, re_a;
  logic [1:0]  mode_a = 2'd0;
  logic [4:0]  faddr_a, addr_a;
  logic [7:0]  fdata_a, wdata_a, rdata_a;

  mem_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_addr(faddr_a), .fail_data(fdata_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_write(we_a), .mem_read(re_a),
    .mem_rdata(rdata_a));

  // ---------------- DUT B: 16 x 16 ----------------
  logic        start_b = 1'b0, busy_b, done_b, pass_b, we_b, re_b;
  logic [1:0]  mode_b = 2'd0;
  logic [3:0]  faddr_b, addr_b;
  logic [15:0] fdata_b, wdata_b, rdata_b;

  mem_bist_ctrl #(.ADDR_W(4), .DATA_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_addr(faddr_b), .fail_data(fdata_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_write(we_b), .mem_read(re_b),
    .mem_rdata(rdata_b));

  // Memory models: 1-cycle read latency; A has one optional stuck-at location.
  logic [7:0]  mem_a [32];
  logic [15:0] mem_b [16];
  int          f_addr = -1;
  logic [7:0]  sa0 = 8'h00, sa1 = 8'h00;

  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= (int'(addr_a) == f_addr) ? ((wdata_a & ~sa0) | sa1) : wdata_a;
    if (re_a) rdata_a <= mem_a[addr_a];
    if (we_b) mem_b[addr_b] <= wdata_b;
    if (re_b) rdata_b <= mem_b[addr_b];
  end

  wr_t  wq_a[$], wq_b[$];
  res_t rq_a[$], rq_b[$];
  logic [7:0] lfsr_seq [32];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: pattern values straight from the mode definitions.
  function automatic logic [7:0] pat_a(input int m, input int a);
    case (m)
      0:       return 8'h00;
      1:       return 8'(a);
      2:       return lfsr_seq[a];
      default: return ~(8'(a));
    endcase
  endfunction

  // Expected write stream and result for one run of A under the current fault.
  task automatic plan_a(input int m);
    int first;
    logic [7:0] p, s;
    res_t r;
    first = -1;
    r.fd = 0;
    for (int a = 0; a < 32; a++) begin
      p = pat_a(m, a);
      s = (a == f_addr) ? ((p & ~sa0) | sa1) : p;
      wq_a.push_back('{a: a, d: int'(p)});
      if (first < 0 && s != p) begin first = a; r.fd = int'(s); end
    end
    if (first < 0) begin
      r.pass = 1'b1; r.fa = 0; r.fd = 0; r.busy = 65; r.reads = 32;
    end else begin
      r.pass  = 1'b0;
      r.fa    = first;
      r.busy  = 32 + ((first + 2 < 33) ? first + 2 : 33);
      r.reads = (first + 2 < 32) ? first + 2 : 32;
    end
    rq_a.push_back(r);
  endtask

  task automatic plan_b();
    res_t r;
    for (int a = 0; a < 16; a++) wq_b.push_back('{a: a, d: a});
    r.pass = 1'b1; r.fa = 0; r.fd = 0; r.busy = 33; r.reads = 16;
    rq_b.push_back(r);
  endtask

  // Monitor A
  int busy_a_cnt = 0, rd_a_cnt = 0;
  logic done_a_q = 1'b0;
  wr_t w_a; res_t r_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_a_cnt = 0; rd_a_cnt = 0; done_a_q = 1'b0;
    end else begin
      if (busy_a) busy_a_cnt++;
      if (re_a) rd_a_cnt++;
      if (we_a && re_a) check("a_wr_rd_overlap", 32'd1, 32'd0);
      if (we_a) begin
        if (wq_a.size() == 0) check("a_unexpected_write", 32'd1, 32'd0);
        else begin
          w_a = wq_a.pop_front();
          check("a_waddr", 32'(addr_a), 32'(w_a.a));
          check("a_wdata", 32'(wdata_a), 32'(w_a.d));
        end
      end
      if (done_a && !done_a_q) begin
        if (rq_a.size() == 0) check("a_unexpected_done", 32'd1, 32'd0);
        else begin
          r_a = rq_a.pop_front();
          check("a_pass", 32'(pass_a), 32'(r_a.pass));
          check("a_fail_addr", 32'(faddr_a), 32'(r_a.fa));
          check("a_fail_data", 32'(fdata_a), 32'(r_a.fd));
          check("a_busy_cycles", 32'(busy_a_cnt), 32'(r_a.busy));
          check("a_read_cycles", 32'(rd_a_cnt), 32'(r_a.reads));
          check("a_busy_low_at_done", 32'(busy_a), 32'd0);
        end
        busy_a_cnt = 0; rd_a_cnt = 0;
      end
      done_a_q = done_a;
    end
  end

  // Monitor B
  int busy_b_cnt = 0, rd_b_cnt = 0;
  logic done_b_q = 1'b0;
  wr_t w_b; res_t r_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_b_cnt = 0; rd_b_cnt = 0; done_b_q = 1'b0;
    end else begin
      if (busy_b) busy_b_cnt++;
      if (re_b) rd_b_cnt++;
      if (we_b) begin
        if (wq_b.size() == 0) check("b_unexpected_write", 32'd1, 32'd0);
        else begin
          w_b = wq_b.pop_front();
          check("b_waddr", 32'(addr_b), 32'(w_b.a));
          check("b_wdata", 32'(wdata_b), 32'(w_b.d));
        end
      end
      if (done_b && !done_b_q) begin
        if (rq_b.size() == 0) check("b_unexpected_done", 32'd1, 32'd0);
        else begin
          r_b = rq_b.pop_front();
          check("b_pass", 32'(pass_b), 32'(r_b.pass));
          check("b_fail_addr", 32'(faddr_b), 32'(r_b.fa));
          check("b_busy_cycles", 32'(busy_b_cnt), 32'(r_b.busy));
          check("b_read_cycles", 32'(rd_b_cnt), 32'(r_b.reads));
        end
        busy_b_cnt = 0; rd_b_cnt = 0;
      end
      done_b_q = done_b;
    end
  end

  task automatic launch_a(input logic [1:0] m);
    plan_a(int'(m));
    @(posedge clk); #1 start_a = 1'b1; mode_a = m;
    @(posedge clk); #1 start_a = 1'b0; mode_a = 2'($urandom);
  endtask

  task automatic wait_done(input bit sel_b);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = sel_b ? done_b : done_a;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_write_addr_a(input int a);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      seen = we_a && (int'(addr_a) == a);
    end
    if (!seen) check("write_addr_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_fault(input int a, input logic [7:0] m0, input logic [7:0] m1);
    f_addr = a; sa0 = m0; sa1 = m1;
  endtask

  initial begin
    logic [7:0] s;
    int bitn;
    s = 8'h01;
    for (int i = 0; i < 32; i++) begin
      lfsr_seq[i] = s;
      s = {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
    end

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs_a", 32'({busy_a, done_a, pass_a, faddr_a, fdata_a, addr_a, we_a, re_a}), 32'd0);
    check("reset_wdata_a", 32'(wdata_a), 32'd0);
    check("reset_outs_b", 32'({busy_b, done_b, pass_b, faddr_b, we_b, re_b}), 32'd0);
    rst_n = 1'b1;

    // Mode 0, good memory
    set_fault(-1, 8'h00, 8'h00);
    launch_a(2'd0); wait_done(1'b0);

    // Mode 1, bit 0 stuck-at-0 at address 5
    set_fault(5, 8'h01, 8'h00);
    launch_a(2'd1); wait_done(1'b0);

    // Mode 2, LFSR, good memory
    set_fault(-1, 8'h00, 8'h00);
    launch_a(2'd2); wait_done(1'b0);

    // Mode 3 with a failing location; start pulsed mid-write must be ignored
    set_fault(20, 8'h01, 8'h00);
    launch_a(2'd3);
    wait_write_addr_a(3);
    start_a = 1'b1; mode_a = 2'd1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done(1'b0);
    // start held in DONE: next cycle is busy with cleared results
    set_fault(-1, 8'h00, 8'h00);
    plan_a(3);
    start_a = 1'b1; mode_a = 2'd3;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("restart_busy", 32'(busy_a), 32'd1);
    check("restart_cleared", 32'({done_a, pass_a, faddr_a, fdata_a}), 32'd0);
    wait_done(1'b0);

    // Reset mid-write at address 10; start during reset is ignored
    launch_a(2'd1);
    wait_write_addr_a(10);
    rst_n = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; start_a = 1'b0;
    check("midreset_outs", 32'({busy_a, done_a, pass_a, faddr_a, fdata_a, addr_a, we_a, re_a}), 32'd0);
    check("midreset_wdata", 32'(wdata_a), 32'd0);
    wq_a.delete(); rq_a.delete();
    @(posedge clk); #1;
    check("midreset_idle", 32'({busy_a, we_a, re_a}), 32'd0);
    launch_a(2'd2); wait_done(1'b0);

    // Randomized runs with optional stuck-at faults
    for (int k = 0; k < 10; k++) begin
      bitn = $urandom_range(0, 7);
      if ($urandom_range(0, 2) == 0) set_fault(-1, 8'h00, 8'h00);
      else if ($urandom_range(0, 1) == 0) set_fault($urandom_range(0, 31), 8'(1 << bitn), 8'h00);
      else set_fault($urandom_range(0, 31), 8'h00, 8'(1 << bitn));
      launch_a(2'($urandom));
      wait_done(1'b0);
    end

    // 16-bit wide, 16-deep instance, mode 1
    plan_b();
    @(posedge clk); #1 start_b = 1'b1; mode_b = 2'd1;
    @(posedge clk); #1 start_b = 1'b0; mode_b = 2'd0;
    wait_done(1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("queues_drained", 32'(wq_a.size() + rq_a.size() + wq_b.size() + rq_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
